id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mips_pkg.sv | 16 +
 rtl/id_ex_stage_fwd_mux.sv | 33 +++
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline: default widths and the
// ALU operation encodings carried from decode into execute.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef logic [2:0] aluop_t;

  localparam aluop_t ALU_ADD = 3'b000;
  localparam aluop_t ALU_OR  = 3'b001;
  localparam aluop_t ALU_SLT = 3'b010;
  localparam aluop_t ALU_SUB = 3'b011;
  localparam aluop_t ALU_LUI = 3'b100;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Two-source bypass mux for one ALU source operand. EX/MEM has priority
// over MEM/WB, and register index 0 is never bypassed because it always
// reads as zero in the register file.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic [REG_W-1:0]  src_idx,
  input  logic [DATA_W-1:0] src_val,
  input  logic [REG_W-1:0]  exm_wreg,
  input  logic              exm_regwrite,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [REG_W-1:0]  mwb_wreg,
  input  logic              mwb_regwrite,
  input  logic [DATA_W-1:0] mwb_result,
  output logic [DATA_W-1:0] fwd_val
);

  // Pick the youngest in-flight producer of src_idx, else the register-file value.
  always_comb begin
    fwd_val = src_val;
    if (src_idx != '0) begin
      if (exm_regwrite && (exm_wreg == src_idx)) begin
        fwd_val = exm_result;
      end else if (mwb_regwrite && (mwb_wreg == src_idx)) begin
        fwd_val = mwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand resolution and hazard stall.
// Build option: define ID_EX_FWD_EN to enable EX/MEM and MEM/WB bypassing.
// Without it, bypass inputs are ignored and the stage stalls on any held
// register-writing producer whose destination matches an incoming source.
//
// Handshake: a transfer on either side happens on a rising edge where
// valid and ready are both 1. in_ready never depends on in_ready itself;
// out_valid is a pure register output. While out_valid=1 and out_ready=0
// every held field is frozen. flush squashes both the held and incoming
// instruction and wins over a capture.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_aluop,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [15:0]       in_imm,
  input  logic              in_alusrc,
  input  logic              in_sext,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_wreg,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              flush,
  input  logic [REG_W-1:0]  exm_wreg,
  input  logic [REG_W-1:0]  mwb_wreg,
  input  logic              exm_regwrite,
  input  logic              mwb_regwrite,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [DATA_W-1:0] mwb_result,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [2:0]        out_aluop,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_wreg,
  output logic              out_regwrite,
  output logic              out_memread
);

  logic              valid_q;
  aluop_t            aluop_q;
  logic [DATA_W-1:0] rs_val_q;
  logic [DATA_W-1:0] rt_val_q;
  logic [15:0]       imm_q;
  logic              alusrc_q;
  logic              sext_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  wreg_q;
  logic              regwrite_q;
  logic              memread_q;

  logic              hazard_src;
  logic              src_match;
  logic              load_use;
  logic              capture;
  logic [DATA_W-1:0] a_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] imm_ext;

`ifdef ID_EX_FWD_EN
  // Only a load cannot be bypassed in time.
  assign hazard_src = memread_q;
`else
  // With no bypass network every pending register write is a hazard.
  assign hazard_src = memread_q | regwrite_q;
`endif

  assign src_match = (wreg_q == in_rs) | (wreg_q == in_rt);
  assign load_use  = in_valid & valid_q & hazard_src & (wreg_q != '0) & src_match;
  assign in_ready  = (~valid_q | out_ready) & ~load_use;
  assign capture   = in_valid & in_ready;

  // Pipeline register: flush squashes, capture loads, drain leaves a bubble, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      aluop_q    <= ALU_ADD;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      sext_q     <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else if (capture) begin
      valid_q    <= 1'b1;
      aluop_q    <= in_aluop;
      rs_val_q   <= in_rs_val;
      rt_val_q   <= in_rt_val;
      imm_q      <= in_imm;
      alusrc_q   <= in_alusrc;
      sext_q     <= in_sext;
      rs_q       <= in_rs;
      rt_q       <= in_rt;
      wreg_q     <= in_wreg;
      regwrite_q <= in_regwrite;
      memread_q  <= in_memread;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef ID_EX_FWD_EN
  fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .src_idx      (rs_q),
    .src_val      (rs_val_q),
    .exm_wreg     (exm_wreg),
    .exm_regwrite (exm_regwrite),
    .exm_result   (exm_result),
    .mwb_wreg     (mwb_wreg),
    .mwb_regwrite (mwb_regwrite),
    .mwb_result   (mwb_result),
    .fwd_val      (a_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .src_idx      (rt_q),
    .src_val      (rt_val_q),
    .exm_wreg     (exm_wreg),
    .exm_regwrite (exm_regwrite),
    .exm_result   (exm_result),
    .mwb_wreg     (mwb_wreg),
    .mwb_regwrite (mwb_regwrite),
    .mwb_result   (mwb_result),
    .fwd_val      (rt_fwd)
  );
`else
  assign a_fwd  = rs_val_q;
  assign rt_fwd = rt_val_q;

  // Bypass ports and held source indices have no consumer in this build.
  logic unused_bypass;
  assign unused_bypass = ^{exm_wreg, exm_regwrite, exm_result,
                           mwb_wreg, mwb_regwrite, mwb_result, rs_q, rt_q};
`endif

  // lui relies on the same path: the ALU shifts the low 16 bits of out_b.
  assign imm_ext = sext_q ? {{(DATA_W-16){imm_q[15]}}, imm_q}
                          : {{(DATA_W-16){1'b0}}, imm_q};

  assign out_valid      = valid_q;
  assign out_aluop      = aluop_q;
  assign out_a          = a_fwd;
  assign out_b          = alusrc_q ? imm_ext : rt_fwd;
  assign out_store_data = rt_fwd;
  assign out_wreg       = wreg_q;
  assign out_regwrite   = valid_q & regwrite_q;
  assign out_memread    = valid_q & memread_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage. Follows the ID_EX_FWD_EN build option so the
// reference model matches whichever configuration is compiled.
`timescale 1ns/1ps
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

`ifdef ID_EX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  aluop;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic        alusrc;
    logic        sext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic        regwrite;
    logic        memread;
  } instr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  instr_t      cur;
  logic        in_valid, in_ready, flush, out_ready;
  logic [4:0]  exm_wreg, mwb_wreg;
  logic        exm_regwrite, mwb_regwrite;
  logic [31:0] exm_result, mwb_result;
  logic        out_valid, out_regwrite, out_memread;
  logic [2:0]  out_aluop;
  logic [31:0] out_a, out_b, out_store_data;
  logic [4:0]  out_wreg;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_aluop       (cur.aluop),
    .in_rs_val      (cur.rs_val),
    .in_rt_val      (cur.rt_val),
    .in_imm         (cur.imm),
    .in_alusrc      (cur.alusrc),
    .in_sext        (cur.sext),
    .in_rs          (cur.rs),
    .in_rt          (cur.rt),
    .in_wreg        (cur.wreg),
    .in_regwrite    (cur.regwrite),
    .in_memread     (cur.memread),
    .flush          (flush),
    .exm_wreg       (exm_wreg),
    .mwb_wreg       (mwb_wreg),
    .exm_regwrite   (exm_regwrite),
    .mwb_regwrite   (mwb_regwrite),
    .exm_result     (exm_result),
    .mwb_result     (mwb_result),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_aluop      (out_aluop),
    .out_a          (out_a),
    .out_b          (out_b),
    .out_store_data (out_store_data),
    .out_wreg       (out_wreg),
    .out_regwrite   (out_regwrite),
    .out_memread    (out_memread)
  );

  // ---------------- scoreboard state ----------------
  instr_t exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Value a source operand should see: youngest matching producer, never r0.
  function automatic logic [31:0] model_operand(input logic [4:0] idx, input logic [31:0] val);
    if (FWD_EN && idx != 5'd0 && exm_regwrite && exm_wreg == idx) return exm_result;
    if (FWD_EN && idx != 5'd0 && mwb_regwrite && mwb_wreg == idx) return mwb_result;
    return val;
  endfunction

  function automatic logic [31:0] model_imm(input logic [15:0] imm, input logic sext);
    int v;
    if (sext) v = int'($signed(imm));
    else      v = int'(imm);
    return 32'(v);
  endfunction

  function automatic instr_t mk(input logic [2:0] op, input logic [4:0] rs, input logic [31:0] rs_val,
                                input logic [4:0] rt, input logic [31:0] rt_val, input logic [15:0] imm,
                                input logic alusrc, input logic sext, input logic [4:0] wreg,
                                input logic regwrite, input logic memread);
    instr_t t;
    t.aluop = op; t.rs = rs; t.rs_val = rs_val; t.rt = rt; t.rt_val = rt_val;
    t.imm = imm; t.alusrc = alusrc; t.sext = sext; t.wreg = wreg;
    t.regwrite = regwrite; t.memread = memread;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.aluop    = 3'($urandom_range(0, 4));
    t.rs_val   = $urandom;
    t.rt_val   = $urandom;
    t.imm      = 16'($urandom);
    t.alusrc   = 1'($urandom_range(0, 1));
    t.sext     = 1'($urandom_range(0, 1));
    t.rs       = 5'($urandom_range(0, 3));
    t.rt       = 5'($urandom_range(0, 3));
    t.wreg     = 5'($urandom_range(0, 3));
    t.regwrite = 1'($urandom_range(0, 1));
    t.memread  = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  // ---------------- monitor ----------------
  // Mid-cycle: compare what the DUT shows against the model, then advance the model.
  always @(negedge clk) begin : monitor
    instr_t h;
    logic   held, lu, er;
    if (!rst_n) begin
      check("reset_out_valid", 32'(out_valid), 32'(0));
      check("reset_out_regwrite", 32'(out_regwrite), 32'(0));
      exp_q.delete();
    end else begin
      held = (exp_q.size() != 0);
      h    = held ? exp_q[0] : '0;
      lu   = in_valid && held && (h.wreg != 5'd0) && (h.memread || (!FWD_EN && h.regwrite))
             && (h.wreg == cur.rs || h.wreg == cur.rt);
      er   = (!held || out_ready) && !lu;
      check("in_ready", 32'(in_ready), 32'(er));
      check("out_valid", 32'(out_valid), 32'(held));
      if (held) begin
        check("out_aluop", 32'(out_aluop), 32'(h.aluop));
        check("out_a", out_a, model_operand(h.rs, h.rs_val));
        check("out_b", out_b, h.alusrc ? model_imm(h.imm, h.sext) : model_operand(h.rt, h.rt_val));
        check("out_store_data", out_store_data, model_operand(h.rt, h.rt_val));
        check("out_wreg", 32'(out_wreg), 32'(h.wreg));
        check("out_regwrite", 32'(out_regwrite), 32'(h.regwrite));
        check("out_memread", 32'(out_memread), 32'(h.memread));
      end else begin
        check("idle_out_regwrite", 32'(out_regwrite), 32'(0));
        check("idle_out_memread", 32'(out_memread), 32'(0));
      end
      if (held && (flush || out_ready)) void'(exp_q.pop_front());
      if (!flush && in_valid && er) exp_q.push_back(cur);
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; cur = '0;
    exm_wreg = '0; mwb_wreg = '0; exm_regwrite = 1'b0; mwb_regwrite = 1'b0;
    exm_result = '0; mwb_result = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Plain add, no bypass.
    cur = mk(ALU_ADD, 5'd3, 32'd5, 5'd4, 32'd7, 16'h0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
    in_valid = 1'b1; step();
    in_valid = 1'b0; step();

    // Bypass priority on held rs=8: EX/MEM first, then MEM/WB.
    cur = mk(ALU_OR, 5'd8, 32'h99, 5'd2, 32'h5, 16'h0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    in_valid = 1'b1; out_ready = 1'b0; step();
    in_valid = 1'b0;
    exm_regwrite = 1'b1; exm_wreg = 5'd8; exm_result = 32'h11;
    mwb_regwrite = 1'b1; mwb_wreg = 5'd8; mwb_result = 32'h22; step();
    exm_wreg = 5'd0; step();
    exm_regwrite = 1'b0; mwb_regwrite = 1'b0; out_ready = 1'b1; step();

    // Load-use: held load to r9, next instruction reads r9.
    cur = mk(ALU_ADD, 5'd1, 32'h100, 5'd2, 32'h0, 16'h4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1);
    in_valid = 1'b1; step();
    cur = mk(ALU_SUB, 5'd9, 32'h33, 5'd5, 32'h44, 16'h0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
    step();
    step();
    in_valid = 1'b0; step();

    // Immediate extension of 0x8000.
    cur = mk(ALU_ADD, 5'd1, 32'h1, 5'd2, 32'h2, 16'h8000, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    in_valid = 1'b1; step();
    cur = mk(ALU_LUI, 5'd0, 32'h0, 5'd2, 32'h2, 16'h8000, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0);
    step();
    in_valid = 1'b0; step();

    // Three-cycle output stall, then flush with a new instruction offered.
    cur = mk(ALU_SLT, 5'd6, 32'h60, 5'd7, 32'h70, 16'h0, 1'b0, 1'b0, 5'd15, 1'b1, 1'b1);
    in_valid = 1'b1; out_ready = 1'b0; step();
    in_valid = 1'b0; step(); step(); step();
    cur = mk(ALU_ADD, 5'd1, 32'h1, 5'd1, 32'h1, 16'h0, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0);
    in_valid = 1'b1; flush = 1'b1; step();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; step();

    // Reset asserted between edges while stalled.
    cur = mk(ALU_OR, 5'd2, 32'hA, 5'd3, 32'hB, 16'h0, 1'b0, 1'b0, 5'd17, 1'b1, 1'b1);
    in_valid = 1'b1; out_ready = 1'b0; step();
    in_valid = 1'b0; step();
    #2 rst_n = 1'b0;
    #1 check("async_reset_out_valid", 32'(out_valid), 32'(0));
    check("async_reset_out_memread", 32'(out_memread), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    cur = mk(ALU_ADD, 5'd3, 32'h3, 5'd0, 32'h9, 16'h0, 1'b0, 1'b0, 5'd18, 1'b1, 1'b0);
    in_valid = 1'b1; step();
    in_valid = 1'b0; step();

    // Randomized traffic with bypass sources, stalls and occasional flush.
    for (int i = 0; i < 600; i++) begin
      cur          = rand_instr();
      in_valid     = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      exm_regwrite = 1'($urandom_range(0, 1));
      mwb_regwrite = 1'($urandom_range(0, 1));
      exm_wreg     = 5'($urandom_range(0, 3));
      mwb_wreg     = 5'($urandom_range(0, 3));
      exm_result   = $urandom;
      mwb_result   = $urandom;
      step();
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
